ext_drift_ctrl: RTL and testbench
=================================

EXT_DRIFT_CTRL -- requirements
Module: ext_drift_ctrl

Interface
REQ-001 Parameter: DT_W, default 3, width of the drift-time value.
REQ-002 Parameter: DT_RST, default 3, drift time loaded at reset.
REQ-003 Parameter: CNT_W, default 8, width of the commit counter.
REQ-004 Port: clk  input  1  sector clock; all state changes on its rising edge.
REQ-005 Port: rst_n  input  1  reset, asynchronous assert, active low.
REQ-006 Port: cfg_valid  input  1  new drift-time request present.
REQ-007 Port: cfg_dt  input  DT_W  requested drift time, sampled on accept.
REQ-008 Port: cfg_ready  output  1  controller can accept a request.
REQ-009 Port: cfg_abort  input  1  cancel an update in progress.
REQ-010 Port: drifttime  output  DT_W  committed drift time driven to every sector hit extender.
REQ-011 Port: ext_mask  output  1  forces all extender inputs to zero while high.
REQ-012 Port: busy  output  1  high whenever state is not IDLE.
REQ-013 Port: upd_done  output  1  one-cycle pulse when a request completes.
REQ-014 Port: upd_cnt  output  CNT_W  number of committed changes.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, DRAIN and COMMIT.
REQ-016 cfg_ready SHALL equal (state==IDLE), combinationally.
REQ-017 A request SHALL be accepted on a rising edge where cfg_valid and cfg_ready are both 1; cfg_dt is latched into a pending register.
REQ-018 If the accepted cfg_dt equals drifttime:
- state SHALL stay IDLE;
- ext_mask SHALL stay 0;
- upd_done SHALL be 1 in the next cycle;
- upd_cnt SHALL be unchanged.
REQ-019 If the accepted cfg_dt differs from drifttime:
- state SHALL move to DRAIN;
- ext_mask SHALL be registered to 1;
- the drain counter SHALL be loaded with drifttime+1, computed at DT_W+1 bits with no overflow.
REQ-020 In DRAIN the counter SHALL decrement by 1 each cycle; on the edge where it equals 1, state SHALL move to COMMIT.
- DRAIN therefore lasts old drifttime+1 cycles, which flushes every in-flight extended hit.
REQ-021 COMMIT SHALL last one cycle. On its exit edge:
- drifttime <= pending;
- ext_mask <= 0;
- upd_done <= 1 for exactly one cycle;
- upd_cnt increments, saturating at all-ones;
- state <= IDLE.
REQ-022 ext_mask SHALL be high for exactly old drifttime+2 consecutive cycles for a changing update.
REQ-023 drifttime SHALL never change except on a COMMIT exit edge or on reset.
REQ-024 cfg_abort sampled high in DRAIN SHALL take precedence over counter expiry:
- state <= IDLE;
- ext_mask <= 0;
- drifttime unchanged;
- no upd_done;
- upd_cnt unchanged.
REQ-025 cfg_abort SHALL be ignored in IDLE and in COMMIT; a commit cannot be cancelled.
REQ-026 cfg_valid while busy SHALL NOT be accepted and SHALL NOT disturb the update in progress; the requester holds the request until cfg_ready.
REQ-027 busy SHALL equal (state!=IDLE).
REQ-028 upd_done SHALL be a registered output.
REQ-029 cfg_dt=0 SHALL be legal.
- DRAIN lasts old drifttime+1 cycles, as for any other value.
- With drifttime=0, DRAIN lasts 1 cycle.

Reset
REQ-030 On rst_n low, asynchronously:
- state=IDLE, drifttime=DT_RST, ext_mask=0, upd_done=0, upd_cnt=0;
- pending=0 and the drain counter=0.
REQ-031 Reset asserted during DRAIN or COMMIT SHALL discard the pending value; drifttime returns to DT_RST.
REQ-032 After rst_n deasserts, the first accept SHALL be possible on the first rising edge.

Verification
REQ-033 Reset release, then cfg_dt=5 accepted at cycle 0 ->
- ext_mask high cycles 1-5;
- drifttime=5 and upd_done=1 at cycle 6;
- upd_cnt=1.
REQ-034 cfg_dt=3 accepted with drifttime=3 -> upd_done=1 next cycle, ext_mask never high, upd_cnt unchanged.
REQ-035 With drifttime=3, cfg_dt=1 accepted, then cfg_abort pulsed in the 2nd DRAIN cycle ->
- ext_mask low the next cycle;
- drifttime stays 3;
- no upd_done.
REQ-036 cfg_valid held high with cfg_dt=6 during an update to 2 ->
- the second request is accepted only in the first IDLE cycle after upd_done;
- the final drifttime is 6;
- upd_cnt advances by 2.
REQ-037 rst_n pulsed low mid-DRAIN -> all outputs immediately take reset values, with drifttime=DT_RST.
REQ-038 With CNT_W=2, perform 5 changing commits -> upd_cnt saturates at 3.

Source files
------------

// File: rtl/ext_drift_ctrl_if.sv
// Configuration handshake and status bundle between a drift-time requester
// and ext_drift_ctrl.
interface ext_drift_ctrl_if #(
    parameter int DT_W  = 3,
    parameter int CNT_W = 8
);
    logic             cfg_valid;
    logic [DT_W-1:0]  cfg_dt;
    logic             cfg_ready;
    logic             cfg_abort;
    logic [DT_W-1:0]  drifttime;
    logic             ext_mask;
    logic             busy;
    logic             upd_done;
    logic [CNT_W-1:0] upd_cnt;

    modport slave (
        input  cfg_valid, cfg_dt, cfg_abort,
        output cfg_ready, drifttime, ext_mask, busy, upd_done, upd_cnt
    );

    modport master (
        output cfg_valid, cfg_dt, cfg_abort,
        input  cfg_ready, drifttime, ext_mask, busy, upd_done, upd_cnt
    );
endinterface

// File: rtl/ext_drift_ctrl.sv
// Drift-time update controller: masks the hit extenders, drains in-flight
// extended hits for old drifttime+1 cycles, then commits the new value.
module ext_drift_ctrl #(
    parameter int DT_W   = 3,
    parameter int DT_RST = 3,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    ext_drift_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, DRAIN, COMMIT} state_t;

    state_t           state_q, state_d;
    logic [DT_W-1:0]  dt_q, dt_d;
    logic [DT_W-1:0]  pend_q, pend_d;
    logic [DT_W:0]    drain_q, drain_d;
    logic             mask_q, mask_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dt_q    <= DT_W'(DT_RST);
            pend_q  <= '0;
            drain_q <= '0;
            mask_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dt_q    <= dt_d;
            pend_q  <= pend_d;
            drain_q <= drain_d;
            mask_q  <= mask_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dt_d    = dt_q;
        pend_d  = pend_q;
        drain_d = drain_q;
        mask_d  = mask_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.cfg_valid) begin
                    pend_d = bus.cfg_dt;
                    if (bus.cfg_dt == dt_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = DRAIN;
                        mask_d  = 1'b1;
                        // Extra bit keeps drifttime+1 from wrapping at the max value.
                        drain_d = {1'b0, dt_q} + (DT_W+1)'(1);
                    end
                end
            end
            DRAIN: begin
                if (bus.cfg_abort) begin
                    state_d = IDLE;
                    mask_d  = 1'b0;
                end else begin
                    drain_d = drain_q - (DT_W+1)'(1);
                    if (drain_q == (DT_W+1)'(1))
                        state_d = COMMIT;
                end
            end
            COMMIT: begin
                dt_d    = pend_q;
                mask_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
                if (cnt_q != '1)
                    cnt_d = cnt_q + CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cfg_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.drifttime = dt_q;
    assign bus.ext_mask  = mask_q;
    assign bus.upd_done  = done_q;
    assign bus.upd_cnt   = cnt_q;
endmodule

// File: tb/tb_ext_drift_ctrl.sv
// Randomized bench for ext_drift_ctrl against a mask-window reference model;
// a second instance with a 2-bit counter covers saturation.
module tb_ext_drift_ctrl;
    localparam int DT_W = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic valid = 1'b0;
    logic [DT_W-1:0] dt_in = '0;
    logic abort = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ext_drift_ctrl_if #(.DT_W(DT_W), .CNT_W(8)) if_a ();
    ext_drift_ctrl_if #(.DT_W(DT_W), .CNT_W(2)) if_s ();

    assign if_a.cfg_valid = valid;
    assign if_a.cfg_dt    = dt_in;
    assign if_a.cfg_abort = abort;
    assign if_s.cfg_valid = valid;
    assign if_s.cfg_dt    = dt_in;
    assign if_s.cfg_abort = abort;

    ext_drift_ctrl #(.DT_W(DT_W), .DT_RST(3), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    ext_drift_ctrl #(.DT_W(DT_W), .DT_RST(3), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .bus(if_s.slave));

    // Model: an update is a window of mask cycles; the last one is the commit cycle.
    int m_dt, m_pend, m_left, m_commits;
    bit m_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_dt = 3; m_pend = 0; m_left = 0; m_commits = 0; m_done = 0;
    endtask

    task automatic model_step(input bit v, input int d, input bit a);
        m_done = 0;
        if (m_left == 0) begin
            if (v) begin
                m_pend = d;
                if (d == m_dt) m_done = 1;
                else m_left = m_dt + 2;
            end
        end else if (m_left > 1 && a) begin
            m_left = 0;
        end else if (m_left == 1) begin
            m_dt = m_pend;
            m_commits++;
            m_done = 1;
            m_left = 0;
        end else begin
            m_left--;
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".ready"}, 32'(if_a.cfg_ready), 32'(m_left == 0));
        chk({ph, ".busy"},  32'(if_a.busy),      32'(m_left != 0));
        chk({ph, ".mask"},  32'(if_a.ext_mask),  32'(m_left != 0));
        chk({ph, ".dt"},    32'(if_a.drifttime), 32'(m_dt));
        chk({ph, ".done"},  32'(if_a.upd_done),  32'(m_done));
        chk({ph, ".cnt"},   32'(if_a.upd_cnt),   32'(m_commits > 255 ? 255 : m_commits));
        chk({ph, ".scnt"},  32'(if_s.upd_cnt),   32'(m_commits > 3 ? 3 : m_commits));
        chk({ph, ".sdt"},   32'(if_s.drifttime), 32'(m_dt));
    endtask

    task automatic step(input bit v, input int d, input bit a);
        valid = v; dt_in = DT_W'(d); abort = a;
        @(posedge clk);
        model_step(v, d, a);
        #1;
        check_all("cyc");
    endtask

    // Reset pulse landing between edges; outputs must clear without a clock.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst");
        #1 rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #12;
        check_all("init");
        rst_n = 1'b1;

        // Change 3->5: mask for 5 cycles, commit, done.
        step(1, 5, 0);
        repeat (7) step(0, 0, 0);
        // Same value: done next cycle, no mask.
        step(1, 5, 0);
        repeat (2) step(0, 0, 0);

        // Abort in the second drain cycle from drifttime=3.
        do_reset();
        step(1, 1, 0);
        step(0, 0, 0);
        step(0, 0, 1);
        repeat (3) step(0, 0, 0);

        // Held request while updating to 2.
        step(1, 2, 0);
        repeat (12) step(1, 6, 0);
        step(0, 0, 0);

        // Mid-drain reset.
        step(1, 7, 0);
        step(0, 0, 0);
        do_reset();
        step(1, 0, 0);
        repeat (6) step(0, 0, 0);

        // Five-plus changing commits, including drifttime 0 drains.
        for (int i = 0; i < 6; i++) begin
            step(1, (i % 2 == 0) ? 0 : 7, 0);
            repeat (10) step(0, 0, 0);
        end

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            step($urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
                 $urandom_range(0, 9) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
